// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Central stall / flush scheduler for the five-stage RV64 pipeline.
//            Each cycle it decides which pipeline registers hold, which load a
//            bubble and whether a control-flow redirect is taken. It merges:
//              - memory wait states (dmem_busy), highest priority
//              - the multi-cycle multiply/divide unit (MDU) occupying EX
//              - the decode-stage load-use bubble (id_bubble)
//              - fetch wait states and wrong-path fetch responses (imem_busy)
//            It sequences the shared MDU with a latency counter, remembers
//            fetch responses that belong to a squashed path (drop_pending)
//            and counts cycles in which fetch is stalled.
//
// Ports    :
//   clk            in   clock, single domain
//   reset          in   asynchronous, active-high
//   id_bubble      in   decode source depends on an in-flight load
//   ex_mdu_start   in   valid MDU instruction currently in EX
//   ex_mdu_div     in   1 = div/rem, 0 = mul (qualifies ex_mdu_start)
//   ex_redirect    in   EX resolves a taken branch / jump
//   imem_busy      in   fetch response not yet available
//   dmem_busy      in   MEM-stage access not complete
//   stall_if/id/ex/mem out  stage register holds
//   kill_if        out  IF/ID loads a bubble
//   bubble_id      out  ID/EX loads a bubble
//   bubble_ex      out  EX/MEM loads a bubble
//   bubble_mem     out  MEM/WB loads a bubble
//   redirect_take  out  fetch PC loads the redirect target this cycle
//   mdu_busy       out  MDU is counting down its latency
//   mdu_done       out  MDU result valid for the EX instruction
//   stall_cycles   out  wrapping count of cycles with stall_if = 1
//
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
   parameter int MUL_LAT = 3,    // EX occupancy of MUL/MULW (>= 2)
   parameter int DIV_LAT = 65,   // EX occupancy of DIV/REM family (>= 2)
   parameter int CNT_W   = 7     // must be able to hold DIV_LAT-1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_bubble,
   input  logic        ex_mdu_start,
   input  logic        ex_mdu_div,
   input  logic        ex_redirect,
   input  logic        imem_busy,
   input  logic        dmem_busy,
   output logic        stall_if,
   output logic        stall_id,
   output logic        stall_ex,
   output logic        stall_mem,
   output logic        kill_if,
   output logic        bubble_id,
   output logic        bubble_ex,
   output logic        bubble_mem,
   output logic        redirect_take,
   output logic        mdu_busy,
   output logic        mdu_done,
   output logic [31:0] stall_cycles
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

   // Counter load values: the cycle in which the instruction is first seen
   // in EX (still IDLE) is one of the LAT stall cycles, so BUSY lasts LAT-1.
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   mdu_state_t        state;
   mdu_state_t        state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              drop_pending;
   logic              drop_nxt;
   logic              ex_hold;
   logic              discard;

   // -------------------------------------------------------------------------
   // MDU state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // MDU next-state logic
   // A memory stall freezes the start and the DONE->IDLE hand-off (the EX
   // instruction cannot move on while MEM is blocked), but an operation that
   // is already running keeps counting.
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      mdu_busy  = 1'b0;
      mdu_done  = 1'b0;
      case (state)
         IDLE: begin
            if (ex_mdu_start && !dmem_busy) begin
               state_nxt = BUSY;
               cnt_nxt   = ex_mdu_div ? DIV_CNT : MUL_CNT;
            end
         end
         BUSY: begin
            mdu_busy = 1'b1;
            if (cnt == CNT_ONE) begin
               state_nxt = DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt - CNT_ONE;
            end
         end
         DONE: begin
            // ex_mdu_start is still high here for the finishing instruction;
            // it is deliberately ignored so the unit does not restart.
            mdu_done = 1'b1;
            if (!dmem_busy) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Stall / bubble / redirect decision
   // -------------------------------------------------------------------------
   always_comb begin
      stall_if      = 1'b0;
      stall_id      = 1'b0;
      stall_ex      = 1'b0;
      stall_mem     = 1'b0;
      kill_if       = 1'b0;
      bubble_id     = 1'b0;
      bubble_ex     = 1'b0;
      bubble_mem    = 1'b0;
      redirect_take = 1'b0;

      ex_hold = ((state == IDLE) && ex_mdu_start) || (state == BUSY);
      // A wrong-path response arriving this cycle: it is thrown away.
      discard = drop_pending && !imem_busy;

      if (dmem_busy) begin
         stall_if   = 1'b1;
         stall_id   = 1'b1;
         stall_ex   = 1'b1;
         stall_mem  = 1'b1;
         bubble_mem = 1'b1;
      end else if (ex_hold) begin
         stall_if   = 1'b1;
         stall_id   = 1'b1;
         stall_ex   = 1'b1;
         bubble_ex  = 1'b1;
      end else if (id_bubble) begin
         stall_if   = 1'b1;
         stall_id   = 1'b1;
         bubble_id  = 1'b1;
      end else if (imem_busy || drop_pending) begin
         // While waiting on a dropped response IF holds; on the cycle the
         // dropped response shows up IF is released so fetch can move on.
         stall_if   = imem_busy;
         kill_if    = 1'b1;
      end

      if (discard) begin
         kill_if = 1'b1;
      end

      // A taken branch can only be acted on once EX itself is free to move;
      // it then squashes the younger IF and ID contents, overriding any
      // load-use hold in decode.
      redirect_take = ex_redirect && !stall_ex;
      if (redirect_take) begin
         kill_if   = 1'b1;
         bubble_id = 1'b1;
         stall_id  = 1'b0;
         stall_if  = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Wrong-path fetch tracking
   // A redirect taken while a fetch is outstanding leaves a response in
   // flight for the old path; it is dropped on arrival. A further redirect
   // during that wait still only leaves one stale response outstanding.
   // -------------------------------------------------------------------------
   always_comb begin
      drop_nxt = drop_pending;
      if (redirect_take && imem_busy) begin
         drop_nxt = 1'b1;
      end else if (!imem_busy) begin
         drop_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_pending <= 1'b0;
      end else begin
         drop_pending <= drop_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Fetch-stall cycle counter (free-running, wraps naturally)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= 32'd0;
      end else if (stall_if) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Self-checking bench for pipe_ctrl. Directed scenarios check the
//            documented cycle-exact behaviour against literal expectations;
//            a randomized run compares every output against a behavioural
//            model that tracks the MDU as "cycles left / result ready".
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

   localparam int MUL_LAT = 3;
   localparam int DIV_LAT = 65;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_bubble, ex_mdu_start, ex_mdu_div, ex_redirect;
   logic        imem_busy, dmem_busy;
   logic        stall_if, stall_id, stall_ex, stall_mem;
   logic        kill_if, bubble_id, bubble_ex, bubble_mem;
   logic        redirect_take, mdu_busy, mdu_done;
   logic [31:0] stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(7)) dut (
      .clk(clk), .reset(reset),
      .id_bubble(id_bubble), .ex_mdu_start(ex_mdu_start),
      .ex_mdu_div(ex_mdu_div), .ex_redirect(ex_redirect),
      .imem_busy(imem_busy), .dmem_busy(dmem_busy),
      .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
      .stall_mem(stall_mem), .kill_if(kill_if), .bubble_id(bubble_id),
      .bubble_ex(bubble_ex), .bubble_mem(bubble_mem),
      .redirect_take(redirect_take), .mdu_busy(mdu_busy),
      .mdu_done(mdu_done), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Reference model: MDU as remaining-cycle count plus result-ready flag
   // ---------------------------------------------------------------------
   int          m_left;
   bit          m_ready;
   bit          m_drop;
   logic [31:0] m_cnt;
   logic [10:0] e_vec;   // {sif,sid,sex,smem,kif,bid,bex,bmem,rt,busy,done}

   function automatic logic [10:0] dut_vec();
      return {stall_if, stall_id, stall_ex, stall_mem, kill_if, bubble_id,
              bubble_ex, bubble_mem, redirect_take, mdu_busy, mdu_done};
   endfunction

   function automatic void model_reset();
      m_left = 0; m_ready = 0; m_drop = 0; m_cnt = 32'd0;
   endfunction

   function automatic void model_eval();
      bit busy, idle, hold;
      bit sif, sid, sex, smem, kif, bid, bex, bmem, rt;
      busy = (m_left != 0);
      idle = !busy && !m_ready;
      hold = (idle && ex_mdu_start) || busy;
      {sif, sid, sex, smem, kif, bid, bex, bmem} = '0;
      if (dmem_busy) begin
         {sif, sid, sex, smem, bmem} = '1;
      end else if (hold) begin
         {sif, sid, sex, bex} = '1;
      end else if (id_bubble) begin
         {sif, sid, bid} = '1;
      end else if (imem_busy || m_drop) begin
         sif = imem_busy; kif = 1;
      end
      if (m_drop && !imem_busy) kif = 1;
      rt = ex_redirect && !sex;
      if (rt) begin kif = 1; bid = 1; sid = 0; sif = 0; end
      e_vec = {sif, sid, sex, smem, kif, bid, bex, bmem, rt, busy, m_ready};
   endfunction

   function automatic void model_commit();
      bit rt, sif, busy, idle;
      sif  = e_vec[10];
      rt   = e_vec[2];
      busy = (m_left != 0);
      idle = !busy && !m_ready;
      if (busy) begin
         m_left--;
         if (m_left == 0) m_ready = 1;
      end else if (m_ready) begin
         if (!dmem_busy) m_ready = 0;
      end else if (idle && ex_mdu_start && !dmem_busy) begin
         m_left = (ex_mdu_div ? DIV_LAT : MUL_LAT) - 1;
      end
      if (rt && imem_busy) m_drop = 1;
      else if (!imem_busy) m_drop = 0;
      if (sif) m_cnt = m_cnt + 32'd1;
   endfunction

   // Drive inputs just after a falling edge, let combinational outputs settle.
   task automatic step(input bit idb, st, dv, rd, ib, db);
      id_bubble = idb; ex_mdu_start = st; ex_mdu_div = dv;
      ex_redirect = rd; imem_busy = ib; dmem_busy = db;
      #1;
      model_eval();
   endtask

   task automatic next_cycle();
      model_commit();
      @(negedge clk);
   endtask

   // ---------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1;
      id_bubble = 0; ex_mdu_start = 0; ex_mdu_div = 0;
      ex_redirect = 0; imem_busy = 0; dmem_busy = 0;
      @(negedge clk); @(negedge clk);
      #1;
      n_checks++;
      if (dut_vec() !== 11'd0) begin
         n_fail++; $display("FAIL reset_outputs got=%b exp=%b", dut_vec(), 11'd0);
      end
      n_checks++;
      if (stall_cycles !== 32'd0) begin
         n_fail++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_mul();
      for (int k = 0; k <= 5; k++) begin
         step(0, k <= 3, 0, 0, 0, 0);
         n_checks++;
         if ({stall_ex, bubble_ex, mdu_busy, mdu_done} !==
             {k < 3, k < 3, (k == 1 || k == 2), k == 3}) begin
            n_fail++;
            $display("FAIL mul_seq k=%0d got sex/bex/busy/done=%b%b%b%b exp=%b%b%b%b",
                     k, stall_ex, bubble_ex, mdu_busy, mdu_done,
                     k < 3, k < 3, (k == 1 || k == 2), k == 3);
         end
         next_cycle();
      end
   endtask

   task automatic test_div_dmem();
      for (int k = 0; k <= 70; k++) begin
         bit db;
         db = (k >= 65 && k <= 67);
         step(0, k <= 68, 1, 0, 0, db);
         n_checks++;
         if ({stall_ex, mdu_busy, mdu_done, bubble_mem} !==
             {(k <= 64) || db, (k >= 1 && k <= 64), (k >= 65 && k <= 68), db}) begin
            n_fail++;
            $display("FAIL div_seq k=%0d got sex/busy/done/bmem=%b%b%b%b exp=%b%b%b%b",
                     k, stall_ex, mdu_busy, mdu_done, bubble_mem,
                     (k <= 64) || db, (k >= 1 && k <= 64), (k >= 65 && k <= 68), db);
         end
         next_cycle();
      end
   endtask

   task automatic test_id_bubble_redirect();
      step(1, 0, 0, 0, 0, 0);
      n_checks++;
      if ({stall_if, stall_id, bubble_id, stall_ex, redirect_take} !== 5'b11100) begin
         n_fail++;
         $display("FAIL id_bubble got=%b exp=11100",
                  {stall_if, stall_id, bubble_id, stall_ex, redirect_take});
      end
      next_cycle();
      step(1, 0, 0, 1, 0, 0);
      n_checks++;
      if ({redirect_take, kill_if, bubble_id, stall_id, stall_if} !== 5'b11100) begin
         n_fail++;
         $display("FAIL id_bubble_redirect got=%b exp=11100",
                  {redirect_take, kill_if, bubble_id, stall_id, stall_if});
      end
      next_cycle();
      step(0, 0, 0, 0, 0, 0);
      next_cycle();
   endtask

   task automatic test_redirect_wait();
      // Redirect raised together with a MUL: it waits for EX to free up.
      for (int k = 0; k <= 4; k++) begin
         step(0, k <= 3, 0, k <= 3, 0, 0);
         n_checks++;
         if ({redirect_take, stall_ex} !== {k == 3, k < 3}) begin
            n_fail++;
            $display("FAIL redirect_wait k=%0d got rt/sex=%b%b exp=%b%b",
                     k, redirect_take, stall_ex, k == 3, k < 3);
         end
         next_cycle();
      end
   endtask

   task automatic test_drop_pending();
      step(0, 0, 0, 1, 1, 0);
      n_checks++;
      if ({redirect_take, kill_if, stall_if} !== 3'b110) begin
         n_fail++; $display("FAIL drop_redirect got=%b exp=110", {redirect_take, kill_if, stall_if});
      end
      next_cycle();
      for (int k = 0; k < 2; k++) begin
         step(0, 0, 0, 0, 1, 0);
         n_checks++;
         if ({dut.drop_pending, stall_if, kill_if} !== 3'b111) begin
            n_fail++;
            $display("FAIL drop_wait k=%0d got drop/sif/kif=%b exp=111",
                     k, {dut.drop_pending, stall_if, kill_if});
         end
         next_cycle();
      end
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({kill_if, stall_if} !== 2'b10) begin
         n_fail++; $display("FAIL drop_discard got kif/sif=%b exp=10", {kill_if, stall_if});
      end
      next_cycle();
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({dut.drop_pending, kill_if, stall_if} !== 3'b000) begin
         n_fail++;
         $display("FAIL drop_cleared got drop/kif/sif=%b exp=000",
                  {dut.drop_pending, kill_if, stall_if});
      end
      next_cycle();
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 35; k++) begin
         step(0, 1, 1, 0, 0, 0);
         next_cycle();
      end
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if ({mdu_busy, stall_ex, dut.cnt} !== {2'b11, 7'd30}) begin
         n_fail++;
         $display("FAIL pre_reset_busy got busy=%b sex=%b cnt=%0d exp busy=1 sex=1 cnt=30",
                  mdu_busy, stall_ex, dut.cnt);
      end
      reset = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if ({dut_vec(), stall_cycles} !== 43'd0) begin
         n_fail++;
         $display("FAIL async_reset got=%b cnt=%0d exp all zero", dut_vec(), stall_cycles);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k <= 4; k++) begin
         step(0, k <= 3, 0, 0, 0, 0);
         n_checks++;
         if ({stall_ex, mdu_done} !== {k < 3, k == 3}) begin
            n_fail++;
            $display("FAIL post_reset_mul k=%0d got sex/done=%b%b exp=%b%b",
                     k, stall_ex, mdu_done, k < 3, k == 3);
         end
         next_cycle();
      end
   endtask

   task automatic test_counter_wrap();
      force dut.stall_cycles = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cycles;
      m_cnt = 32'hFFFF_FFFF;
      for (int k = 0; k < 2; k++) begin
         step(1, 0, 0, 0, 0, 0);
         next_cycle();
      end
      step(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (stall_cycles !== 32'd1) begin
         n_fail++; $display("FAIL counter_wrap got=%0d exp=1", stall_cycles);
      end
      next_cycle();
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         step($urandom_range(99) < 20, $urandom_range(99) < 30,
              $urandom_range(99) < 15, $urandom_range(99) < 20,
              $urandom_range(99) < 30, $urandom_range(99) < 20);
         n_checks++;
         if (dut_vec() !== e_vec) begin
            n_fail++; $display("FAIL rand_outputs k=%0d got=%b exp=%b", k, dut_vec(), e_vec);
         end
         n_checks++;
         if (stall_cycles !== m_cnt) begin
            n_fail++; $display("FAIL rand_stall_cycles k=%0d got=%0d exp=%0d", k, stall_cycles, m_cnt);
         end
         next_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div_dmem();
      test_id_bubble_redirect();
      test_redirect_wait();
      test_drop_pending();
      test_async_reset();
      test_counter_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
